// File: rtl/cache_fill_responder.sv
// Block-fill responder between a cache and pipelined main memory: issues one read per word,
// streams returns into the data array, writes the tag on the last word. Option: CACHE_FILL_CRITICAL_WORD_FIRST_EN.
module cache_fill_responder #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               miss_detected,
    input  logic [15:0]                        miss_address,
    input  logic [15:0]                        memory_data,
    input  logic                               memory_data_valid,
    output logic                               fsm_busy,
    output logic                               memory_req,
    output logic [15:0]                        memory_address,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_word_offset,
    output logic [15:0]                        fill_data,
    output logic                               write_tag_array
);
    // state | meaning
    // IDLE  | waiting for a miss; stray memory returns are ignored
    // FILL  | issuing word reads and accepting returns until the last word lands

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = OFF_W + 1;
    localparam int BLK_W = 16 - OFF_W - 1;

    generate
        if ((WORDS_PER_BLOCK < 2) || ((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0))
            $error("WORDS_PER_BLOCK must be a power of two >= 2");
        if (MEM_LATENCY < 1)
            $error("MEM_LATENCY must be at least 1");
    endgenerate

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state;
    logic [BLK_W-1:0]   blk;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   ret_cnt;
    logic [15:0]        last_addr;
    logic [OFF_W-1:0]   issue_off;
    logic [OFF_W-1:0]   ret_off;
    logic [15:0]        req_addr;
    logic               issuing;
    logic               last_ret;
    logic               unused_addr_bits;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0]   start;

    // Offset arithmetic wraps naturally at OFF_W bits, giving the mod-block order.
    assign issue_off        = start + issue_cnt[OFF_W-1:0];
    assign ret_off          = start + ret_cnt[OFF_W-1:0];
    assign unused_addr_bits = miss_address[0];
`else
    assign issue_off        = issue_cnt[OFF_W-1:0];
    assign ret_off          = ret_cnt[OFF_W-1:0];
    assign unused_addr_bits = ^miss_address[OFF_W:0];
`endif

    assign issuing  = (state == FILL) && (issue_cnt < CNT_W'(WORDS_PER_BLOCK));
    assign last_ret = (ret_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
    assign req_addr = {blk, issue_off, 1'b0};

    assign fsm_busy          = (state == FILL) || miss_detected;
    assign memory_req        = issuing;
    assign memory_address    = issuing ? req_addr : last_addr;
    assign cache_word_offset = (state == FILL) ? ret_off : '0;
    assign write_data_array  = (state == FILL) && memory_data_valid;
    assign write_tag_array   = write_data_array && last_ret;
    assign fill_data         = memory_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            blk       <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            last_addr <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            start     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        blk       <= miss_address[15:OFF_W+1];
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                        start     <= miss_address[OFF_W:1];
`endif
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        last_addr <= req_addr;
                    end
                    // Completion is count-based so return gaps never matter.
                    if (memory_data_valid) begin
                        ret_cnt <= ret_cnt + 1'b1;
                        if (last_ret)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_responder.sv
// Directed bench for cache_fill_responder with a pipelined memory model driving returns.
module tb_cache_fill_responder;
    localparam int WPB = 8;
    localparam int LAT = 4;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  cache_word_offset;
    logic [15:0] fill_data;
    logic        write_tag_array;

    int compared   = 0;
    int mismatched = 0;

    int          n_req, n_wr, n_tag, tag_cyc, busy_cnt, end_cyc, noreq_cyc, pass_err;
    logic [15:0] noreq_addr;
    logic [15:0] req_addr [32];
    int          req_cyc  [32];
    logic [2:0]  wr_off   [32];
    logic [15:0] wr_data  [32];
    int          wr_cyc   [32];

    always #5 clk = ~clk;

    cache_fill_responder #(.WORDS_PER_BLOCK(WPB), .MEM_LATENCY(LAT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_req        (memory_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .cache_word_offset (cache_word_offset),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    function automatic logic [2:0] exp_off(input logic [15:0] a, input int i);
        logic [2:0] s;
        s = CWF ? a[3:1] : 3'd0;
        return s + 3'(i);
    endfunction

    function automatic logic [15:0] exp_addr(input logic [15:0] a, input int i);
        return {a[15:4], exp_off(a, i), 1'b0};
    endfunction

    // Memory model: each request returns LAT cycles later, at most one valid per 'gap' cycles.
    task automatic drive_fill(input logic [15:0] addr, input int gap, input bit drop_miss,
                              input int abort_after);
        logic [15:0] q_addr [32];
        int          q_rdy  [32];
        int          qh = 0, qt = 0, last_v = -100;
        n_req = 0; n_wr = 0; n_tag = 0; tag_cyc = -1; busy_cnt = 0; end_cyc = -1;
        noreq_cyc = -1; noreq_addr = 16'hxxxx; pass_err = 0;
        for (int k = 0; k < 32; k++) begin
            req_addr[k] = 16'hxxxx; req_cyc[k] = -1;
            wr_off[k] = 3'bxxx; wr_data[k] = 16'hxxxx; wr_cyc[k] = -1;
        end
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == 0) begin
                miss_detected = 1'b1;
                miss_address  = addr;
            end
            if (drop_miss && c == 3) begin
                miss_detected = 1'b0;
                miss_address  = 16'hFFFE;
            end
            if (qh != qt && q_rdy[qh] <= c && (c - last_v) >= gap) begin
                memory_data_valid = 1'b1;
                memory_data       = 16'hA000 | {13'd0, q_addr[qh][3:1]};
                qh++;
                last_v = c;
            end else begin
                memory_data_valid = 1'b0;
                memory_data       = 16'h5A5A;
            end
            #1;
            if (fsm_busy) busy_cnt++;
            if (fill_data !== memory_data) pass_err++;
            if (write_data_array && n_wr < 32) begin
                wr_off[n_wr] = cache_word_offset;
                wr_data[n_wr] = fill_data;
                wr_cyc[n_wr] = c;
                n_wr++;
            end
            if (write_tag_array) begin
                n_tag++;
                tag_cyc = c;
            end
            if (memory_req && n_req < 32) begin
                req_addr[n_req] = memory_address;
                req_cyc[n_req]  = c;
                n_req++;
                q_addr[qt] = memory_address;
                q_rdy[qt]  = c + LAT;
                qt++;
            end else if (fsm_busy && c > 0 && noreq_cyc < 0) begin
                noreq_cyc  = c;
                noreq_addr = memory_address;
            end
            end_cyc = c;
            if (n_tag > 0) break;
            if (abort_after > 0 && n_wr >= abort_after) break;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        miss_detected = 1'b0;
        memory_data_valid = 1'b0;
        memory_data = 16'h0000;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        miss_detected = 1'b0;
        miss_address = 16'h0000;
        memory_data = 16'h0000;
        memory_data_valid = 1'b0;
        #12;
        compared++; if (fsm_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", fsm_busy); end
        compared++; if (memory_req !== 1'b0) begin mismatched++; $display("FAIL reset_req got %b want 0", memory_req); end
        compared++; if (memory_address !== 16'h0) begin mismatched++; $display("FAIL reset_addr got %h want 0000", memory_address); end
        compared++; if (write_data_array !== 1'b0) begin mismatched++; $display("FAIL reset_wda got %b want 0", write_data_array); end
        compared++; if (cache_word_offset !== 3'd0) begin mismatched++; $display("FAIL reset_off got %0d want 0", cache_word_offset); end
        compared++; if (write_tag_array !== 1'b0) begin mismatched++; $display("FAIL reset_tag got %b want 0", write_tag_array); end
        compared++; if (fill_data !== 16'h0) begin mismatched++; $display("FAIL reset_fill got %h want 0000", fill_data); end
        @(negedge clk);
        rst_n = 1'b1;
        memory_data = 16'h1234;
        #1;
        compared++; if (fill_data !== 16'h1234) begin mismatched++; $display("FAIL passthru got %h want 1234", fill_data); end
        compared++; if (write_data_array !== 1'b0) begin mismatched++; $display("FAIL idle_nowrite got %b want 0", write_data_array); end
    endtask

    task automatic test_basic_fill();
        drive_fill(16'h1236, 1, 1'b0, 0);
        compared++; if (n_req !== 8) begin mismatched++; $display("FAIL basic_nreq got %0d want 8", n_req); end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (req_addr[i] !== exp_addr(16'h1236, i) || req_cyc[i] !== i + 1) begin
                mismatched++;
                $display("FAIL basic_req[%0d] got %h@%0d want %h@%0d", i, req_addr[i], req_cyc[i], exp_addr(16'h1236, i), i + 1);
            end
        end
        compared++; if (n_wr !== 8) begin mismatched++; $display("FAIL basic_nwr got %0d want 8", n_wr); end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (wr_off[i] !== exp_off(16'h1236, i) || wr_data[i] !== (16'hA000 | {13'd0, exp_off(16'h1236, i)}) || wr_cyc[i] !== i + 5) begin
                mismatched++;
                $display("FAIL basic_wr[%0d] got off %0d data %h @%0d want off %0d @%0d", i, wr_off[i], wr_data[i], wr_cyc[i], exp_off(16'h1236, i), i + 5);
            end
        end
        compared++; if (n_tag !== 1 || tag_cyc !== 12) begin mismatched++; $display("FAIL basic_tag got %0d@%0d want 1@12", n_tag, tag_cyc); end
        compared++; if (busy_cnt !== 13) begin mismatched++; $display("FAIL basic_busy got %0d want 13", busy_cnt); end
        compared++; if (noreq_addr !== exp_addr(16'h1236, 7)) begin mismatched++; $display("FAIL basic_addr_hold got %h want %h", noreq_addr, exp_addr(16'h1236, 7)); end
        compared++; if (pass_err !== 0) begin mismatched++; $display("FAIL basic_passthru got %0d errors want 0", pass_err); end
        idle_cycle();
        compared++; if (fsm_busy !== 1'b0 || memory_req !== 1'b0) begin mismatched++; $display("FAIL basic_idle got busy %b req %b want 0 0", fsm_busy, memory_req); end
    endtask

    task automatic test_critical_word_first();
        drive_fill(16'h123A, 1, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (req_addr[i] !== exp_addr(16'h123A, i)) begin
                mismatched++;
                $display("FAIL cwf_req[%0d] got %h want %h", i, req_addr[i], exp_addr(16'h123A, i));
            end
            compared++;
            if (wr_off[i] !== exp_off(16'h123A, i) || wr_data[i] !== (16'hA000 | {13'd0, exp_off(16'h123A, i)})) begin
                mismatched++;
                $display("FAIL cwf_wr[%0d] got off %0d data %h want off %0d", i, wr_off[i], wr_data[i], exp_off(16'h123A, i));
            end
        end
        compared++; if (n_tag !== 1 || tag_cyc !== 12) begin mismatched++; $display("FAIL cwf_tag got %0d@%0d want 1@12", n_tag, tag_cyc); end
        idle_cycle();
    endtask

    task automatic test_gapped_returns();
        drive_fill(16'h2468, 3, 1'b1, 0);
        compared++; if (n_wr !== 8) begin mismatched++; $display("FAIL gap_nwr got %0d want 8", n_wr); end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (req_addr[i] !== exp_addr(16'h2468, i) || wr_off[i] !== exp_off(16'h2468, i) || wr_cyc[i] !== 5 + 3 * i) begin
                mismatched++;
                $display("FAIL gap_word[%0d] got req %h off %0d @%0d want req %h off %0d @%0d", i, req_addr[i], wr_off[i], wr_cyc[i], exp_addr(16'h2468, i), exp_off(16'h2468, i), 5 + 3 * i);
            end
        end
        compared++; if (n_tag !== 1 || tag_cyc !== 26) begin mismatched++; $display("FAIL gap_tag got %0d@%0d want 1@26", n_tag, tag_cyc); end
        compared++; if (busy_cnt !== 27) begin mismatched++; $display("FAIL gap_busy got %0d want 27", busy_cnt); end
        idle_cycle();
        compared++; if (fsm_busy !== 1'b0) begin mismatched++; $display("FAIL gap_idle_busy got %b want 0", fsm_busy); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        miss_detected = 1'b0;
        memory_data_valid = 1'b1;
        memory_data = 16'hDEAD;
        #1;
        compared++;
        if (write_data_array !== 1'b0 || write_tag_array !== 1'b0 || fsm_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL stray_valid got wda %b tag %b busy %b want 0 0 0", write_data_array, write_tag_array, fsm_busy);
        end
        drive_fill(16'h3000, 1, 1'b0, 0);
        compared++; if (n_wr !== 8 || wr_off[0] !== exp_off(16'h3000, 0) || wr_data[0] !== 16'hA000) begin mismatched++; $display("FAIL b2b_first got n %0d off0 %0d data0 %h want 8 0 a000", n_wr, wr_off[0], wr_data[0]); end
        compared++; if (tag_cyc !== 12) begin mismatched++; $display("FAIL b2b_first_tag got %0d want 12", tag_cyc); end
        drive_fill(16'h4000, 1, 1'b0, 0);
        compared++; if (req_addr[0] !== 16'h4000 || req_cyc[0] !== 1) begin mismatched++; $display("FAIL b2b_second_req got %h@%0d want 4000@1", req_addr[0], req_cyc[0]); end
        compared++; if (n_wr !== 8 || n_tag !== 1 || tag_cyc !== 12) begin mismatched++; $display("FAIL b2b_second_done got n %0d tag %0d@%0d want 8 1@12", n_wr, n_tag, tag_cyc); end
        compared++; if (busy_cnt !== 13) begin mismatched++; $display("FAIL b2b_second_busy got %0d want 13", busy_cnt); end
        idle_cycle();
    endtask

    task automatic test_reset_mid_fill();
        drive_fill(16'h5550, 1, 1'b0, 3);
        compared++; if (n_wr !== 3 || end_cyc !== 7) begin mismatched++; $display("FAIL rst_pre got %0d writes @%0d want 3 @7", n_wr, end_cyc); end
        compared++; if (memory_req !== 1'b1) begin mismatched++; $display("FAIL rst_pre_req got %b want 1", memory_req); end
        rst_n = 1'b0;
        miss_detected = 1'b0;
        memory_data_valid = 1'b0;
        memory_data = 16'h0000;
        #1;
        compared++;
        if (fsm_busy !== 1'b0 || memory_req !== 1'b0 || memory_address !== 16'h0 || write_data_array !== 1'b0 ||
            cache_word_offset !== 3'd0 || write_tag_array !== 1'b0 || fill_data !== 16'h0) begin
            mismatched++;
            $display("FAIL rst_outputs got busy %b req %b addr %h wda %b off %0d tag %b fill %h want all 0",
                     fsm_busy, memory_req, memory_address, write_data_array, cache_word_offset, write_tag_array, fill_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            memory_data_valid = 1'b1;
            memory_data = 16'hBEEF;
            #1;
            compared++;
            if (write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin
                mismatched++;
                $display("FAIL late_valid[%0d] got wda %b tag %b want 0 0", i, write_data_array, write_tag_array);
            end
        end
        idle_cycle();
        drive_fill(16'h6000, 1, 1'b0, 0);
        compared++; if (n_req !== 8 || n_wr !== 8) begin mismatched++; $display("FAIL post_rst_counts got req %0d wr %0d want 8 8", n_req, n_wr); end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (wr_off[i] !== exp_off(16'h6000, i) || req_addr[i] !== exp_addr(16'h6000, i)) begin
                mismatched++;
                $display("FAIL post_rst_word[%0d] got off %0d req %h want off %0d req %h", i, wr_off[i], req_addr[i], exp_off(16'h6000, i), exp_addr(16'h6000, i));
            end
        end
        compared++; if (n_tag !== 1 || tag_cyc !== 12) begin mismatched++; $display("FAIL post_rst_tag got %0d@%0d want 1@12", n_tag, tag_cyc); end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_critical_word_first();
        test_gapped_returns();
        test_back_to_back();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
